// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Decode/EX issue stage that maps R/I/SPECIAL2 fields onto the ALU
//            op code and operands, behind a registered valid/ready handshake.
// Options  : ALU_ISSUE_SKID_EN adds a skid register and a registered in_ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage #(
  parameter int         DATA_W = 32,
  parameter logic [3:0] ILL_OP = 4'b0000,
  parameter int         CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [5:0]        opcode_i,
  input  logic [5:0]        funct_i,
  input  logic [4:0]        shamt_i,
  input  logic [15:0]       imm16_i,
  input  logic [DATA_W-1:0] rs_val_i,
  input  logic [DATA_W-1:0] rt_val_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [3:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  illegal_cnt_o
);

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_SPEC2 = 6'b011100;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              ill;
  } uop_t;

  uop_t              dec_uop;
  uop_t              main_q, main_d;
  logic              main_vld_q, main_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              out_fire;

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] shamt_zext;
  logic [DATA_W-1:0] rs_shamt;
  logic [DATA_W-1:0] lui_val;

  assign imm_sext   = {{(DATA_W-16){imm16_i[15]}}, imm16_i};
  assign imm_zext   = {{(DATA_W-16){1'b0}}, imm16_i};
  assign shamt_zext = {{(DATA_W-5){1'b0}}, shamt_i};
  assign rs_shamt   = {{(DATA_W-5){1'b0}}, rs_val_i[4:0]};
  assign lui_val    = {imm16_i, {(DATA_W-16){1'b0}}};

  // Fixed shifts are issued as their variable forms with shamt as operand b.
  always_comb begin
    dec_uop.op  = ILL_OP;
    dec_uop.a   = '0;
    dec_uop.b   = '0;
    dec_uop.ill = 1'b1;
    unique case (opcode_i)
      OPC_RTYPE: begin
        dec_uop.ill = 1'b0;
        dec_uop.a   = rs_val_i;
        dec_uop.b   = rt_val_i;
        unique case (funct_i)
          6'b100100: dec_uop.op = 4'b0000;
          6'b100101: dec_uop.op = 4'b0001;
          6'b100110: dec_uop.op = 4'b0010;
          6'b100111: dec_uop.op = 4'b0011;
          6'b100001: dec_uop.op = 4'b0100;
          6'b100011: dec_uop.op = 4'b0101;
          6'b100000: dec_uop.op = 4'b0110;
          6'b100010: dec_uop.op = 4'b0111;
          6'b101010: dec_uop.op = 4'b1100;
          6'b101011: dec_uop.op = 4'b1101;
          6'b000000: begin dec_uop.op = 4'b1001; dec_uop.a = rt_val_i; dec_uop.b = shamt_zext; end
          6'b000010: begin dec_uop.op = 4'b1011; dec_uop.a = rt_val_i; dec_uop.b = shamt_zext; end
          6'b000100: begin dec_uop.op = 4'b1001; dec_uop.a = rt_val_i; dec_uop.b = rs_shamt;   end
          6'b000110: begin dec_uop.op = 4'b1011; dec_uop.a = rt_val_i; dec_uop.b = rs_shamt;   end
          default: begin
            dec_uop.op  = ILL_OP;
            dec_uop.a   = '0;
            dec_uop.b   = '0;
            dec_uop.ill = 1'b1;
          end
        endcase
      end
      OPC_SPEC2: begin
        if (funct_i == 6'b100000 || funct_i == 6'b100001) begin
          dec_uop.ill = 1'b0;
          dec_uop.a   = rs_val_i;
          dec_uop.op  = funct_i[0] ? 4'b1110 : 4'b1111;
        end
      end
      6'b001000: begin dec_uop.ill = 1'b0; dec_uop.op = 4'b0110; dec_uop.a = rs_val_i; dec_uop.b = imm_sext; end
      6'b001001: begin dec_uop.ill = 1'b0; dec_uop.op = 4'b0100; dec_uop.a = rs_val_i; dec_uop.b = imm_sext; end
      6'b001010: begin dec_uop.ill = 1'b0; dec_uop.op = 4'b1100; dec_uop.a = rs_val_i; dec_uop.b = imm_sext; end
      6'b001011: begin dec_uop.ill = 1'b0; dec_uop.op = 4'b1101; dec_uop.a = rs_val_i; dec_uop.b = imm_sext; end
      6'b001100: begin dec_uop.ill = 1'b0; dec_uop.op = 4'b0000; dec_uop.a = rs_val_i; dec_uop.b = imm_zext; end
      6'b001101: begin dec_uop.ill = 1'b0; dec_uop.op = 4'b0001; dec_uop.a = rs_val_i; dec_uop.b = imm_zext; end
      6'b001110: begin dec_uop.ill = 1'b0; dec_uop.op = 4'b0010; dec_uop.a = rs_val_i; dec_uop.b = imm_zext; end
      6'b001111: begin dec_uop.ill = 1'b0; dec_uop.op = 4'b0001; dec_uop.a = lui_val;  dec_uop.b = '0;       end
      default: ;
    endcase
  end

  assign out_fire = main_vld_q && out_ready_i;
  assign accept   = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_uop.ill && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef ALU_ISSUE_SKID_EN
  uop_t skid_q, skid_d;
  logic skid_vld_q, skid_vld_d;

  assign in_ready_o = !skid_vld_q;

  // The skid entry only fills while main is held, so main is never empty
  // while skid is occupied.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_fire) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = dec_uop;
      end
    end else if (accept) begin
      skid_d     = dec_uop;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
`else
  assign in_ready_o = !main_vld_q || out_ready_i;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
    end else if (accept) begin
      main_d     = dec_uop;
      main_vld_d = 1'b1;
    end else if (out_fire) begin
      main_vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid_o   = main_vld_q;
  assign alu_op_o      = main_q.op;
  assign alu_a_o       = main_q.a;
  assign alu_b_o       = main_q.b;
  assign illegal_o     = main_q.ill;
  assign illegal_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Randomized bench for alu_issue_stage against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } uop_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [5:0]  opcode_i;
  logic [5:0]  funct_i;
  logic [4:0]  shamt_i;
  logic [15:0] imm16_i;
  logic [31:0] rs_val_i;
  logic [31:0] rt_val_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic        illegal_o;
  logic [7:0]  illegal_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  uop_t q[$];
  int   m_cnt = 0;

  alu_issue_stage dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .opcode_i(opcode_i), .funct_i(funct_i), .shamt_i(shamt_i), .imm16_i(imm16_i),
    .rs_val_i(rs_val_i), .rt_val_i(rt_val_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic uop_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    uop_t u;
    u.op = op; u.a = a; u.b = b; u.ill = 1'b0;
    return u;
  endfunction

  // Reference decode straight from the instruction table.
  function automatic uop_t ref_uop(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                                   input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
    uop_t        u;
    logic [31:0] se, ze;
    se = {{16{imm[15]}}, imm};
    ze = {16'h0, imm};
    u  = '{op: 4'b0000, a: 32'h0, b: 32'h0, ill: 1'b1};
    if (opc == 6'h00) begin
      case (fn)
        6'h24: u = mk(4'h0, rs, rt);
        6'h25: u = mk(4'h1, rs, rt);
        6'h26: u = mk(4'h2, rs, rt);
        6'h27: u = mk(4'h3, rs, rt);
        6'h21: u = mk(4'h4, rs, rt);
        6'h23: u = mk(4'h5, rs, rt);
        6'h20: u = mk(4'h6, rs, rt);
        6'h22: u = mk(4'h7, rs, rt);
        6'h2A: u = mk(4'hC, rs, rt);
        6'h2B: u = mk(4'hD, rs, rt);
        6'h00: u = mk(4'h9, rt, 32'(sh));
        6'h02: u = mk(4'hB, rt, 32'(sh));
        6'h04: u = mk(4'h9, rt, rs % 32);
        6'h06: u = mk(4'hB, rt, rs % 32);
        default: ;
      endcase
    end else if (opc == 6'h1C) begin
      if (fn == 6'h20) u = mk(4'hF, rs, 32'h0);
      if (fn == 6'h21) u = mk(4'hE, rs, 32'h0);
    end else begin
      case (opc)
        6'h08: u = mk(4'h6, rs, se);
        6'h09: u = mk(4'h4, rs, se);
        6'h0A: u = mk(4'hC, rs, se);
        6'h0B: u = mk(4'hD, rs, se);
        6'h0C: u = mk(4'h0, rs, ze);
        6'h0D: u = mk(4'h1, rs, ze);
        6'h0E: u = mk(4'h2, rs, ze);
        6'h0F: u = mk(4'h1, imm * 32'h10000, 32'h0);
        default: ;
      endcase
    end
    return u;
  endfunction

  // Occupancy rule: skid build holds up to two, plain build frees on consume.
  function automatic bit m_in_ready();
`ifdef ALU_ISSUE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready_i;
`endif
  endfunction

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      q.delete();
      m_cnt = 0;
    end else begin
      bit   rdy;
      uop_t u;
      rdy = m_in_ready();
      if (flush_i) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready_i) void'(q.pop_front());
        if (in_valid_i && rdy) begin
          u = ref_uop(opcode_i, funct_i, shamt_i, imm16_i, rs_val_i, rt_val_i);
          q.push_back(u);
          if (u.ill && m_cnt < 255) m_cnt++;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en && !reset_i) begin
      chk("out_valid", out_valid_o, q.size() > 0);
      chk("in_ready", in_ready_o, m_in_ready());
      chk("illegal_cnt", illegal_cnt_o, m_cnt[7:0]);
      if (q.size() > 0) begin
        chk("alu_op", alu_op_o, q[0].op);
        chk("alu_a", alu_a_o, q[0].a);
        chk("alu_b", alu_b_o, q[0].b);
        chk("illegal", illegal_o, q[0].ill);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                           input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
    opcode_i = opc; funct_i = fn; shamt_i = sh; imm16_i = imm; rs_val_i = rs; rt_val_i = rt;
  endtask

  task automatic send(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
    set_instr(opc, fn, sh, imm, rs, rt);
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic rand_instr();
    logic [5:0] rfn [14] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23, 6'h20,
                             6'h22, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h04, 6'h06};
    int         r;
    r = $urandom_range(0, 9);
    shamt_i  = 5'($urandom);
    imm16_i  = 16'($urandom);
    rs_val_i = $urandom;
    rt_val_i = $urandom;
    funct_i  = 6'($urandom);
    opcode_i = 6'($urandom);
    if (r < 5) begin
      opcode_i = 6'h00;
      if (r < 4) funct_i = rfn[$urandom_range(0, 13)];
    end else if (r == 5) begin
      opcode_i = 6'h1C;
      if ($urandom_range(0, 3) != 0) funct_i = 6'h20 + 6'($urandom_range(0, 1));
    end else if (r < 9) begin
      opcode_i = 6'h08 + 6'($urandom_range(0, 7));
    end
  endtask

  task automatic stall_fill(input int cycles);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      rand_instr();
      step();
    end
  endtask

  int saved_cnt;

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    set_instr(6'h0, 6'h0, 5'h0, 16'h0, 32'h0, 32'h0);
    step(); step();
    chk("reset out_valid", out_valid_o, 1'b0);
    chk("reset alu_op", alu_op_o, 4'h0);
    chk("reset cnt", illegal_cnt_o, 8'h0);
    reset_i = 1'b0;
    chk_en  = 1'b1;

    send(6'h00, 6'h20, 5'h0, 16'h0, 32'h7FFFFFFF, 32'h1);
    chk("add op", alu_op_o, 4'b0110);
    chk("add a", alu_a_o, 32'h7FFFFFFF);
    chk("add b", alu_b_o, 32'h1);
    send(6'h00, 6'h00, 5'd4, 16'h0, 32'h12345678, 32'h0000000F);
    chk("sll op", alu_op_o, 4'b1001);
    chk("sll a", alu_a_o, 32'h0000000F);
    chk("sll b", alu_b_o, 32'h00000004);
    send(6'h08, 6'h00, 5'h0, 16'hFFFF, 32'h5, 32'h0);
    chk("addi op", alu_op_o, 4'b0110);
    chk("addi b", alu_b_o, 32'hFFFFFFFF);
    send(6'h0C, 6'h00, 5'h0, 16'hFFFF, 32'h5, 32'h0);
    chk("andi op", alu_op_o, 4'b0000);
    chk("andi b", alu_b_o, 32'h0000FFFF);
    step();

    stall_fill(3);
    chk("stall in_ready", in_ready_o, 1'b0);
    chk("stall out_valid", out_valid_o, 1'b1);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) step();
    chk("drained", out_valid_o, 1'b0);

    stall_fill(3);
    saved_cnt  = m_cnt;
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    set_instr(6'h3F, 6'h0, 5'h0, 16'h0, 32'h1, 32'h2);
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush out_valid", out_valid_o, 1'b0);
    chk("flush cnt", illegal_cnt_o, saved_cnt[7:0]);
    out_ready_i = 1'b1;
    step();

    for (int i = 0; i < 2000; i++) begin
      rand_instr();
      in_valid_i  = ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 7);
      flush_i     = ($urandom_range(0, 31) == 0);
      step();
    end
    flush_i = 1'b0;

    stall_fill(2);
    #2 reset_i = 1'b1;
    #1;
    chk("async out_valid", out_valid_o, 1'b0);
    chk("async op", alu_op_o, 4'h0);
    chk("async a", alu_a_o, 32'h0);
    chk("async b", alu_b_o, 32'h0);
    chk("async illegal", illegal_o, 1'b0);
    chk("async cnt", illegal_cnt_o, 8'h0);
    step();
    reset_i = 1'b0;

    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    set_instr(6'h3F, 6'h00, 5'h0, 16'h1234, 32'hDEAD, 32'hBEEF);
    repeat (300) step();
    in_valid_i = 1'b0;
    chk("sat illegal", illegal_o, 1'b1);
    chk("sat op", alu_op_o, 4'b0000);
    chk("sat a", alu_a_o, 32'h0);
    chk("sat cnt", illegal_cnt_o, 8'hFF);
    step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
